// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM sequencing fetch/decode/execute
// plus the combinational ALU decoder that turns aluop/funct into alucontrol.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       pcwrite, branch, illegal;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; everything not named in a state stays 0
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // zero only matters while branch is high, i.e. in BRANCH
    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    always_comb begin
        alucontrol = 3'b010;
        if (illegal) begin
            alucontrol = 3'b000;
        end else if (aluop == 2'b01) begin
            alucontrol = 3'b110;
        end else if (aluop == 2'b10) begin
            case (funct)
                6'b100010: alucontrol = 3'b110;
                6'b100100: alucontrol = 3'b000;
                6'b100101: alucontrol = 3'b001;
                6'b101010: alucontrol = 3'b111;
                default:   alucontrol = 3'b010;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// state sequence and checks the Moore outputs against hand-derived values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // brief reset pulse between edges, leaves the FSM in FETCH
    task automatic go_fetch();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
        step(); step();
        checks++;
        if (state !== 4'd0 || regwrite !== 1'b0) begin
            errors++; $display("FAIL reset_hold: state=%0d regwrite=%b, want 0/0", state, regwrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || irwrite !== 1'b1 || pcen !== 1'b1 || alusrcb !== 2'b01 || memwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: state=%0d irwrite=%b pcen=%b alusrcb=%b memwrite=%b, want 0/1/1/01/0",
                     state, irwrite, pcen, alusrcb, memwrite);
        end
        step();
        checks++;
        if (state !== 4'd1) begin
            errors++; $display("FAIL reset_decode: state=%0d want 1", state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 6'b100011;
        step(); go_fetch();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (state !== seq[i]) begin
                errors++; $display("FAIL lw_seq[%0d]: state=%0d want %0d", i, state, seq[i]);
            end
            if (i == 3) begin
                checks++;
                if (iord !== 1'b1 || regwrite !== 1'b0) begin
                    errors++; $display("FAIL lw_memrd: iord=%b regwrite=%b want 1/0", iord, regwrite);
                end
            end
            if (i == 4) begin
                checks++;
                if (regwrite !== 1'b1 || memtoreg !== 1'b1 || regdst !== 1'b0 || iord !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_memwb: regwrite=%b memtoreg=%b regdst=%b iord=%b want 1/1/0/0",
                             regwrite, memtoreg, regdst, iord);
                end
            end
            if (i == 2) begin
                checks++;
                if (alusrca !== 1'b1 || alusrcb !== 2'b10 || alucontrol !== 3'b010) begin
                    errors++;
                    $display("FAIL lw_memadr: alusrca=%b alusrcb=%b alucontrol=%b want 1/10/010",
                             alusrca, alusrcb, alucontrol);
                end
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        int wr_cycles = 0;
        op = 6'b101011;
        step(); go_fetch();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            if (memwrite === 1'b1) wr_cycles++;
            checks++;
            if (state !== seq[i]) begin
                errors++; $display("FAIL sw_seq[%0d]: state=%0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (memwrite !== (i == 3) || (i == 3 && iord !== 1'b1)) begin
                errors++; $display("FAIL sw_memwrite[%0d]: memwrite=%b iord=%b want %b/1", i, memwrite, iord, i == 3);
            end
        end
        checks++;
        if (wr_cycles != 1) begin
            errors++; $display("FAIL sw_wr_cycles: got %0d want 1", wr_cycles);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [4] = '{6'b101010, 6'b100100, 6'b100101, 6'b100010};
        logic [2:0] ac [4] = '{3'b111, 3'b000, 3'b001, 3'b110};
        op = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            funct = fn[k];
            step(); go_fetch();
            step();
            checks++;
            if (state !== 4'd1 || alucontrol !== 3'b010 || alusrcb !== 2'b11) begin
                errors++; $display("FAIL rt_decode[%0d]: state=%0d alucontrol=%b alusrcb=%b want 1/010/11",
                                   k, state, alucontrol, alusrcb);
            end
            step();
            checks++;
            if (state !== 4'd6 || alucontrol !== ac[k] || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
                errors++; $display("FAIL rt_execute[%0d]: state=%0d alucontrol=%b alusrca=%b alusrcb=%b want 6/%b/1/00",
                                   k, state, alucontrol, alusrca, alusrcb, ac[k]);
            end
            step();
            checks++;
            if (state !== 4'd7 || regwrite !== 1'b1 || regdst !== 1'b1 || memtoreg !== 1'b0) begin
                errors++; $display("FAIL rt_aluwb[%0d]: state=%0d regwrite=%b regdst=%b memtoreg=%b want 7/1/1/0",
                                   k, state, regwrite, regdst, memtoreg);
            end
            step();
            checks++;
            if (state !== 4'd0) begin
                errors++; $display("FAIL rt_return[%0d]: state=%0d want 0", k, state);
            end
        end
    endtask

    task automatic test_branch_jump();
        op = 6'b000100; zero = 1'b1;
        step(); go_fetch();
        step();
        checks++;
        if (state !== 4'd1 || pcen !== 1'b0) begin
            errors++; $display("FAIL beq_decode: state=%0d pcen=%b want 1/0", state, pcen);
        end
        step();
        checks++;
        if (state !== 4'd8 || pcen !== 1'b1 || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
            errors++; $display("FAIL beq_taken: state=%0d pcen=%b pcsrc=%b alucontrol=%b want 8/1/01/110",
                               state, pcen, pcsrc, alucontrol);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pcen !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken: pcen=%b want 0", pcen);
        end
        step();
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL beq_return: state=%0d want 0", state);
        end
        op = 6'b000010;
        go_fetch();
        step(); step();
        checks++;
        if (state !== 4'd11 || pcen !== 1'b1 || pcsrc !== 2'b10 || irwrite !== 1'b0) begin
            errors++; $display("FAIL j_jump: state=%0d pcen=%b pcsrc=%b irwrite=%b want 11/1/10/0",
                               state, pcen, pcsrc, irwrite);
        end
        step();
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL j_return: state=%0d want 0", state);
        end
    endtask

    task automatic test_addi();
        op = 6'b001000;
        step(); go_fetch();
        step(); step();
        checks++;
        if (state !== 4'd9 || alusrca !== 1'b1 || alusrcb !== 2'b10 || regwrite !== 1'b0) begin
            errors++; $display("FAIL addi_ex: state=%0d alusrca=%b alusrcb=%b regwrite=%b want 9/1/10/0",
                               state, alusrca, alusrcb, regwrite);
        end
        step();
        checks++;
        if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
            errors++; $display("FAIL addi_wb: state=%0d regwrite=%b regdst=%b memtoreg=%b want 10/1/0/0",
                               state, regwrite, regdst, memtoreg);
        end
    endtask

    task automatic test_nop();
        logic [3:0] seq [3] = '{4'd0, 4'd1, 4'd0};
        op = 6'b111111;
        step(); go_fetch();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (state !== seq[i] || regwrite !== 1'b0 || memwrite !== 1'b0) begin
                errors++; $display("FAIL nop_seq[%0d]: state=%0d regwrite=%b memwrite=%b want %0d/0/0",
                                   i, state, regwrite, memwrite, seq[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        op = 6'b101011;
        step(); go_fetch();
        step(); step(); step();
        checks++;
        if (state !== 4'd5 || memwrite !== 1'b1) begin
            errors++; $display("FAIL abort_pre: state=%0d memwrite=%b want 5/1", state, memwrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b0 || state !== 4'd0) begin
            errors++; $display("FAIL abort_now: memwrite=%b state=%0d want 0/0", memwrite, state);
        end
        step(); step();
        checks++;
        if (state !== 4'd0 || irwrite !== 1'b1) begin
            errors++; $display("FAIL abort_hold: state=%0d irwrite=%b want 0/1", state, irwrite);
        end
        reset = 1'b1;
        step();
        checks++;
        if (state !== 4'd1) begin
            errors++; $display("FAIL abort_resume: state=%0d want 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch_jump();
        test_addi();
        test_nop();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Control unit for the multicycle MIPS datapath: a Moore main FSM that sequences fetch/decode/execute across cycles, plus a combinational ALU decoder. Sits inside the processor core beside the datapath. Takes opcode, funct and ALU zero from the datapath and drives every mux select and write enable. The shared instruction/data memory port is time-multiplexed through iord.

Parameters:
STATE_W, 4, width of the state register and of the debug state output

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
op  input  6  instruction[31:26]
funct  input  6  instruction[5:0]
zero  input  1  ALU result == 0
pcen  output  1  PC register enable
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regwrite  output  1  register file write
iord  output  1  memory address select (0=PC, 1=ALUOut)
memtoreg  output  1  writeback select (1=data reg)
regdst  output  1  dest reg select (1=rd, 0=rt)
alusrca  output  1  ALU A select (0=PC, 1=reg A)
alusrcb  output  2  ALU B select (00=B, 01=4, 10=signimm, 11=signimm<<2)
pcsrc  output  2  next-PC select (00=ALU, 01=ALUOut, 10=jump target)
alucontrol  output  3  ALU function
state  output  STATE_W  current state (debug)

Behaviour:
- Asynchronous reset (reset=0): state -> FETCH immediately. All outputs then take FETCH values; no other state is entered while reset is low.
- Main FSM outputs are Moore, decoded from state only. Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are illegal and go to FETCH next cycle with all outputs 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH (executes as a nop)
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Internal signals pcwrite, branch and aluop[1:0] are not ported.
- pcen = pcwrite | (branch & zero), combinational. zero is sampled only while in BRANCH.
- ALU decoder (combinational), alucontrol by aluop:
  - 00 -> 010 (add)
  - 01 -> 110 (sub)
  - 11 -> 010 (add)
  - 10 -> by funct: 100000 -> 010 (add), 100010 -> 110 (sub), 100100 -> 000 (and), 100101 -> 001 (or), 101010 -> 111 (slt); any other funct -> 010.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- memwrite is asserted only in MEMWR and is high for exactly one cycle per sw.
- irwrite is asserted only in FETCH.
- Reset asserted mid-instruction aborts it. Any write enable asserted in the current state drops in the same cycle as reset.

Test Plan:
- Hold reset=0 for 2 cycles, release -> state=0, irwrite=1, pcen=1, alusrcb=01, memwrite=0. Next edge: state=1.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0. In state 4: regwrite=1, memtoreg=1, regdst=0. In state 3: iord=1.
- op=101011 (sw) -> sequence 0,1,2,5,0. memwrite=1 only in state 5, for exactly one cycle, with iord=1.
- op=000000, funct=101010 -> in state 6: alucontrol=111. In state 7: regwrite=1, regdst=1. Repeat with funct 100100 -> alucontrol=000, and funct 100101 -> alucontrol=001.
- op=000100 in BRANCH: zero=1 -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0. op=000010 -> state 11 with pcen=1, pcsrc=10.
- op=111111 -> 0,1,0 with no regwrite/memwrite. Pull reset low during state 5 -> memwrite drops immediately and state=0.
